am_err_monitor: RTL and testbench

- Downstream consumer of the unsigned 8x8 approximate multipliers.
- Streams operand pairs (x, y) and the approximate product z_approx that the multiplier produced for them. Computes the exact product internally and accumulates error statistics over a programmed number of samples.
- Statistics: error count, sum of error distance, max error distance, signed bias.
- Used in characterisation benches and on-chip self-test to score each approximate multiplier variant.

---
 rtl/am_err_monitor.sv | 144 ++++++++++++++
 tb/tb_am_err_monitor.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/am_err_monitor.sv
// Error-statistics monitor for unsigned WxW approximate multipliers: compares each streamed
// approximate product against the exact one and accumulates count, sum, max and bias of the error.
module am_err_monitor #(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned SUM_W = 40
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_samples,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       x,
    input  logic [W-1:0]       y,
    input  logic [2*W-1:0]     z_approx,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [SUM_W-1:0]   sum_ed,
    output logic [2*W-1:0]     max_ed,
    output logic [SUM_W:0]     bias
);

    localparam int unsigned PW = 2 * W;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic               clear, accept;

    logic               s1_valid_q, s1_last_q;
    logic [W-1:0]       s1_x_q, s1_y_q;
    logic [PW-1:0]      s1_z_q;
    logic               s2_valid_q, s2_last_q;
    logic [PW:0]        s2_d_q;

    logic [PW-1:0]      exact_c;
    logic [PW:0]        d_c;
    logic [PW:0]        ed_c;

    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [SUM_W-1:0]   sum_ed_q, sum_ed_d;
    logic [PW-1:0]      max_ed_q, max_ed_d;
    logic [SUM_W:0]     bias_q, bias_d;

    assign accept   = (state_q == StRun) && in_valid;
    assign in_ready = (state_q == StRun);
    assign busy     = (state_q == StRun) || (state_q == StDrain);
    assign done     = (state_q == StDone);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        clear       = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    clear       = 1'b1;
                    remaining_d = num_samples;
                    state_d     = (num_samples != '0) ? StRun : StDone;
                end
            end
            StRun: begin
                if (accept) begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == {{(CNT_W-1){1'b0}}, 1'b1}) state_d = StDrain;
                end
            end
            StDrain: begin
                if (s2_valid_q && s2_last_q) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    // Difference kept as PW+1-bit two's complement so it can span -(2^W-1)^2 .. 2^PW-1.
    always_comb begin
        exact_c = {{W{1'b0}}, s1_x_q} * {{W{1'b0}}, s1_y_q};
        d_c     = {1'b0, s1_z_q} - {1'b0, exact_c};
        ed_c    = s2_d_q[PW] ? (~s2_d_q + 1'b1) : s2_d_q;
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        sum_ed_d  = sum_ed_q;
        max_ed_d  = max_ed_q;
        bias_d    = bias_q;
        if (clear) begin
            err_cnt_d = '0;
            sum_ed_d  = '0;
            max_ed_d  = '0;
            bias_d    = '0;
        end else if (s2_valid_q) begin
            err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, (s2_d_q != '0)};
            sum_ed_d  = sum_ed_q + {{(SUM_W-PW-1){1'b0}}, ed_c};
            bias_d    = bias_q + {{(SUM_W-PW){s2_d_q[PW]}}, s2_d_q};
            if (ed_c > {1'b0, max_ed_q}) max_ed_d = ed_c[PW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_z_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_d_q      <= '0;
            err_cnt_q   <= '0;
            sum_ed_q    <= '0;
            max_ed_q    <= '0;
            bias_q      <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            err_cnt_q   <= err_cnt_d;
            sum_ed_q    <= sum_ed_d;
            max_ed_q    <= max_ed_d;
            bias_q      <= bias_d;
            s1_valid_q  <= accept && !clear;
            s2_valid_q  <= s1_valid_q && !clear;
            s2_last_q   <= s1_last_q;
            s2_d_q      <= d_c;
            if (accept) begin
                s1_x_q    <= x;
                s1_y_q    <= y;
                s1_z_q    <= z_approx;
                s1_last_q <= (remaining_q == {{(CNT_W-1){1'b0}}, 1'b1});
            end
        end
    end

    assign err_cnt = err_cnt_q;
    assign sum_ed  = sum_ed_q;
    assign max_ed  = max_ed_q;
    assign bias    = bias_q;

endmodule

// File: tb/tb_am_err_monitor.sv
// Randomized bench for am_err_monitor: a queue-based reference model of accepted samples and
// their commit times is compared against the DUT every cycle, plus literal expectations.
module tb_am_err_monitor;

    localparam int unsigned W     = 8;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned SUM_W = 40;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [CNT_W-1:0]   num_samples = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [W-1:0]       x = '0;
    logic [W-1:0]       y = '0;
    logic [2*W-1:0]     z_approx = '0;
    logic               busy, done;
    logic [CNT_W-1:0]   err_cnt;
    logic [SUM_W-1:0]   sum_ed;
    logic [2*W-1:0]     max_ed;
    logic [SUM_W:0]     bias;

    am_err_monitor #(.W(W), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y), .z_approx(z_approx),
        .busy(busy), .done(done), .err_cnt(err_cnt), .sum_ed(sum_ed), .max_ed(max_ed),
        .bias(bias)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: phase 0 idle, 1 collecting, 2 waiting for last commit, 3 finished.
    typedef struct {
        int     cyc;
        longint d;
        bit     last;
    } pend_t;

    pend_t  pend[$];
    int     cyc = 0;
    int     phase = 0;
    longint rem = 0;
    longint m_err = 0, m_sum = 0, m_max = 0, m_bias = 0;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic clear_stats();
        m_err = 0; m_sum = 0; m_max = 0; m_bias = 0;
    endtask

    task automatic model_edge();
        int    old;
        pend_t e;
        cyc++;
        if (!rst_n) begin
            phase = 0; rem = 0; pend.delete(); clear_stats();
            return;
        end
        old = phase;
        while (pend.size() > 0 && pend[0].cyc == cyc) begin
            longint ed;
            e  = pend.pop_front();
            ed = (e.d < 0) ? -e.d : e.d;
            if (e.d != 0) m_err++;
            m_sum  += ed;
            m_bias += e.d;
            if (ed > m_max) m_max = ed;
            if (e.last && old == 2) phase = 3;
        end
        if (old == 1 && in_valid) begin
            e.cyc  = cyc + 2;
            e.d    = longint'(z_approx) - longint'(x) * longint'(y);
            e.last = (rem == 1);
            pend.push_back(e);
            rem--;
            if (rem == 0) phase = 2;
        end
        if ((old == 0 || old == 3) && start) begin
            clear_stats();
            pend.delete();
            rem   = longint'(num_samples);
            phase = (num_samples != 0) ? 1 : 3;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("in_ready", longint'(in_ready), longint'(phase == 1));
            check("busy", longint'(busy), longint'(phase == 1 || phase == 2));
            check("done", longint'(done), longint'(phase == 3));
            check("err_cnt", longint'(err_cnt), m_err);
            check("sum_ed", longint'(sum_ed), m_sum);
            check("max_ed", longint'(max_ed), m_max);
            check("bias", longint'($signed(bias)), m_bias);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start       = 1'b1;
        num_samples = CNT_W'(n);
        step();
        start       = 1'b0;
        num_samples = CNT_W'($urandom);
    endtask

    task automatic send(input int xa, input int ya, input int za, input int gap);
        bit acc;
        in_valid = 1'b0;
        repeat (gap) begin
            x = W'($urandom); y = W'($urandom); z_approx = 16'($urandom);
            step();
        end
        x = W'(xa); y = W'(ya); z_approx = 16'(za);
        in_valid = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            acc = in_ready;
            step();
        end
        if (!acc) check("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 100 && !done; k++) step();
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic check_stats(input string tag, input longint e, input longint s,
                               input longint m, input longint b);
        check({tag, "_err_cnt"}, longint'(err_cnt), e);
        check({tag, "_sum_ed"}, longint'(sum_ed), s);
        check({tag, "_max_ed"}, longint'(max_ed), m);
        check({tag, "_bias"}, longint'($signed(bias)), b);
    endtask

    function automatic int rand_z(input int xa, input int ya);
        int ex;
        ex = xa * ya;
        case ($urandom_range(0, 3))
            0: return ex;
            1: return (ex + $urandom_range(0, 40) - 20) & 16'hffff;
            2: return int'($urandom_range(0, 65535));
            default: return ex ^ (1 << $urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        step(); step();
        chk_en = 1'b1;
        check_stats("reset", 0, 0, 0, 0);
        check("reset_busy", longint'(busy), 0);
        check("reset_in_ready", longint'(in_ready), 0);
        rst_n = 1'b1;
        step();

        // Exact multiplier.
        do_start(4);
        send(3, 5, 15, 0); send(255, 255, 65025, 1); send(0, 77, 0, 0); send(128, 2, 256, 2);
        wait_done();
        check_stats("exact", 0, 0, 0, 0);

        // Known errors; model pinned to literals too.
        do_start(3);
        send(255, 255, 0, 0); send(10, 10, 110, 0); send(1, 1, 1, 0);
        wait_done();
        check_stats("known", 2, 65035, 65025, -65015);
        check("model_known_sum", m_sum, 65035);
        check("model_known_bias", m_bias, -65015);

        // Latency/handshake with a gap and a start pulse mid-run.
        do_start(2);
        x = 8'd4; y = 8'd4; z_approx = 16'd17; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        start = 1'b1; num_samples = 16'd7;
        step();
        start = 1'b0;
        step(); step();
        check("lat_busy_mid", longint'(busy), 1);
        x = 8'd6; y = 8'd7; z_approx = 16'd40; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("lat_in_ready_drop", longint'(in_ready), 0);
        check("lat_done_e1", longint'(done), 0);
        step();
        check("lat_done_e1b", longint'(done), 0);
        step();
        check("lat_done_e2", longint'(done), 1);
        check_stats("lat", 2, 3, 2, -1);

        // Zero samples.
        do_start(0);
        check("zero_done", longint'(done), 1);
        check("zero_busy", longint'(busy), 0);
        check_stats("zero", 0, 0, 0, 0);

        // Reset mid-run.
        do_start(5);
        send(9, 9, 80, 0); send(200, 3, 650, 1);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_stats("midrst", 0, 0, 0, 0);
        check("midrst_busy", longint'(busy), 0);
        check("midrst_done", longint'(done), 0);
        do_start(1);
        send(2, 3, 7, 0);
        wait_done();
        check_stats("after_rst", 1, 1, 1, 1);

        // Restart from DONE clears on the start edge.
        do_start(3);
        check("restart_busy", longint'(busy), 1);
        check("restart_done", longint'(done), 0);
        check_stats("restart", 0, 0, 0, 0);
        send(1, 2, 5, 0); send(7, 7, 40, 0); send(100, 100, 10000, 3);
        wait_done();
        check_stats("restart_end", 2, 12, 9, -6);

        // Randomized runs.
        for (int r = 0; r < 15; r++) begin
            int n;
            n = $urandom_range(1, 20);
            do_start(n);
            for (int i = 0; i < n; i++) begin
                int xa, ya;
                xa = $urandom_range(0, 255);
                ya = $urandom_range(0, 255);
                if ($urandom_range(0, 7) == 0) begin
                    start = 1'b1; num_samples = 16'd3;
                end
                send(xa, ya, rand_z(xa, ya), $urandom_range(0, 2));
                start = 1'b0;
            end
            wait_done();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
